// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver.
// The rx line is synchronised, re-aligned on every start bit, sampled at
// mid-bit and shifted LSB first. Each byte lands in a valid/ready holding
// register. A stop bit sampled low raises a framing-error pulse. A byte that
// completes while the holding register is still full raises an overrun pulse.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_pin,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  // Elaboration guard: the mid-bit alignment needs an even oversampling ratio of at least 4.
  if (CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0) begin : g_bad_clks_per_bit
    $error("uart_rx: CLKS_PER_BIT must be even and >= 4");
  end
  if (DATA_BITS < 2) begin : g_bad_data_bits
    $error("uart_rx: DATA_BITS must be >= 2");
  end

  typedef enum logic [2:0] {
    WAIT_IDLE = 3'd0,
    IDLE      = 3'd1,
    START     = 3'd2,
    DATA      = 3'd3,
    STOP      = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic                 sync1_q, sync2_q;
  logic                 rx_s;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 busy_q, busy_d;

  assign rx_s = sync2_q;

  // Two-flop synchroniser for the asynchronous rx line; resets to the idle (high) level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx_pin;
      sync2_q <= sync1_q;
    end
  end

  // State register for the FSM, the counters and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= WAIT_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state logic: framing, bit sampling, holding-register handshake and pulse flags.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    // Consumer handshake. A delivery in the STOP branch below overrides this.
    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end else begin
      rx_valid_d = rx_valid_q;
    end

    case (state_q)
      WAIT_IDLE: begin
        cnt_d = '0;
        if (rx_s) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_IDLE;
        end
      end
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          if (rx_s) begin
            state_d = IDLE;           // short low glitch, not a start bit
          end else begin
            state_d = DATA;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          if (bit_idx_q == IDX_LAST) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + IW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = IDLE;           // allows a start bit right after the stop bit
            if (!rx_valid_q || rx_ready) begin
              rx_data_d  = shift_q;
              rx_valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;       // keep the unconsumed byte, drop the new one
            end
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = WAIT_IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d == START) || (state_d == DATA) || (state_d == STOP);
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;

endmodule
